// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// states, opcodes, ALU op codes, mux selects and the control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the FSM (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [5:0] opCode;
  logic       zero;
  logic       memReady;
  logic       pcEn;
  logic [1:0] pcSource;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       regWrite;
  logic       memToReg;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  opCode, zero, memReady,
    output pcEn, pcSource, iorD, memRead, memWrite, irWrite,
    output regDst, regWrite, memToReg, aluSrcA, aluSrcB, aluOp,
    output illegalOp, state
  );

  modport slave (
    output opCode, zero, memReady,
    input  pcEn, pcSource, iorD, memRead, memWrite, irWrite,
    input  regDst, regWrite, memToReg, aluSrcA, aluSrcB, aluOp,
    input  illegalOp, state
  );
endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Moore output decode: state (plus memReady in FETCH) -> control word.
// Build option MULTICYCLE_ADDI_EN enables the addi states.
import mc_pkg::*;

module mc_out_decode (
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`else
      S_ADDI_EXEC, S_ADDI_WB: ctrl = '0;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next state, pcEn.
// Build option MULTICYCLE_ADDI_EN adds the addi execute/write-back path.
import mc_pkg::*;

module multicycle_ctrl (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t state_q;
  state_t next;
  logic   illegal;
  ctrl_t  dec;
  ctrl_t  c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next;
  end

  always_comb begin
    next    = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:     next = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (bus.opCode == OP_LW) || (bus.opCode == OP_SW):
            next = S_MEM_ADR;
          bus.opCode == OP_RTYPE: next = S_EXECUTE;
          bus.opCode == OP_BEQ:   next = S_BRANCH;
          bus.opCode == OP_J:     next = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          bus.opCode == OP_ADDI:  next = S_ADDI_EXEC;
`endif
          default: begin
            next    = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADR:
        next = (bus.opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = bus.memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    next = S_FETCH;
      S_MEM_WRITE: next = bus.memReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next = S_R_WB;
      S_R_WB:      next = S_FETCH;
      S_BRANCH:    next = S_FETCH;
      S_JUMP:      next = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: next = S_ADDI_WB;
      S_ADDI_WB:   next = S_FETCH;
`else
      S_ADDI_EXEC, S_ADDI_WB: next = S_FETCH;
`endif
      default:     next = S_FETCH;
    endcase
  end

  mc_out_decode u_dec (
    .state     (state_q),
    .mem_ready (bus.memReady),
    .ctrl      (dec)
  );

  // Reset forces every output low in the same cycle, not just after the edge.
  assign c = reset ? '0 : dec;

  assign bus.pcEn      = c.pc_write | (c.pc_write_cond & bus.zero);
  assign bus.pcSource  = c.pc_source;
  assign bus.iorD      = c.iord;
  assign bus.memRead   = c.mem_read;
  assign bus.memWrite  = c.mem_write;
  assign bus.irWrite   = c.ir_write;
  assign bus.regDst    = c.reg_dst;
  assign bus.regWrite  = c.reg_write;
  assign bus.memToReg  = c.mem_to_reg;
  assign bus.aluSrcA   = c.alu_src_a;
  assign bus.aluSrcB   = c.alu_src_b;
  assign bus.aluOp     = c.alu_op;
  assign bus.illegalOp = illegal & ~reset;
  assign bus.state     = reset ? 4'd0 : state_q;

endmodule
